piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 5 +
 rtl/piso_bit_cnt.sv | 18 +
 rtl/piso_serializer.sv | 52 +++++
 tb/tb_piso_serializer.sv | 98 +++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and default width for the PISO serializer
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  localparam int PISO_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: saturating bit counter that flags the final bit of a word
module piso_bit_cnt #(
  parameter int WIDTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_is_last
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_clr ? '0 : (i_inc && !o_is_last) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_is_last = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with load/shift handshakes
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic             i_shift_en,
  output logic             o_sd,
  output logic             o_sd_valid,
  output logic             o_last,
  output logic             o_busy
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             is_last, busy, consume, accept, adv;
  always_comb begin
    busy         = state_q == SHIFT;
    o_last       = busy && is_last;
    consume      = o_last && i_shift_en;
    o_load_ready = !busy || consume;
    accept       = i_load_valid && o_load_ready;
    adv          = busy && i_shift_en && !is_last;
    state_d      = accept ? SHIFT : consume ? IDLE : state_q;
    shreg_d      = accept ? i_data
                 : adv ? (MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]})
                 : shreg_q;
    o_busy       = busy;
    o_sd_valid   = busy;
    o_sd         = busy && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (accept),
    .i_inc    (adv),
    .o_is_last(is_last)
  );
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed checks of both bit orders against a word/index model
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       rst_n, lv, se;
  logic [3:0] data;
  logic       rdy_m, sd_m, val_m, last_m, busy_m;
  logic       rdy_l, sd_l, val_l, last_l, busy_l;
  int         total = 0;
  int         bad = 0;
  logic       m_busy = 1'b0;
  logic [3:0] m_word = '0;
  int         m_k = 0;
  logic [3:0] sipo = '0;
  logic [7:0] hist = '0;
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_load_valid(lv), .o_load_ready(rdy_m),
    .i_shift_en(se), .o_sd(sd_m), .o_sd_valid(val_m), .o_last(last_m), .o_busy(busy_m)
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_load_valid(lv), .o_load_ready(rdy_l),
    .i_shift_en(se), .o_sd(sd_l), .o_sd_valid(val_l), .o_last(last_l), .o_busy(busy_l)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic l, input logic [3:0] d, input logic s);
    logic last_e, rdy_e;
    @(negedge clk);
    rst_n = r; lv = l; data = d; se = s;
    #1;
    last_e = m_busy && m_k == 3;
    rdy_e  = !m_busy || (last_e && s);
    chk("msb_sd", {7'd0, sd_m}, {7'd0, m_busy && m_word[3 - m_k]});
    chk("lsb_sd", {7'd0, sd_l}, {7'd0, m_busy && m_word[m_k]});
    chk("valid", {6'd0, val_m, val_l}, {6'd0, m_busy, m_busy});
    chk("busy", {6'd0, busy_m, busy_l}, {6'd0, m_busy, m_busy});
    chk("last", {6'd0, last_m, last_l}, {6'd0, last_e, last_e});
    chk("ready", {6'd0, rdy_m, rdy_l}, {6'd0, rdy_e, rdy_e});
    if (val_m && s) begin
      sipo = {sipo[2:0], sd_m};
      hist = {hist[6:0], sd_m};
    end
    if (r && last_e && s) chk("loopback", {4'd0, sipo}, {4'd0, m_word});
    @(posedge clk);
    if (!r) begin
      m_busy = 1'b0;
      m_k = 0;
    end else begin
      if (m_busy && s) begin
        if (m_k == 3) m_busy = 1'b0;
        else m_k++;
      end
      if (l && rdy_e) begin
        m_word = d;
        m_k = 0;
        m_busy = 1'b1;
      end
    end
  endtask
  initial begin
    rst_n = 1'b0; lv = 1'b0; se = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    step(0, 1, 4'h7, 1);
    step(1, 1, 4'hA, 1);
    hist = '0;
    repeat (4) step(1, 0, 4'h0, 1);
    chk("single_word", hist, 8'h0A);
    step(1, 0, 4'h0, 1);
    hist = '0;
    step(1, 1, 4'hA, 1);
    repeat (4) step(1, 1, 4'h5, 1);
    repeat (4) step(1, 0, 4'h0, 1);
    chk("back_to_back", hist, 8'hA5);
    step(1, 0, 4'h0, 1);
    step(1, 1, 4'hC, 1);
    step(1, 0, 4'h0, 1);
    repeat (2) step(1, 0, 4'h0, 0);
    repeat (4) step(1, 0, 4'h0, 1);
    step(1, 1, 4'h1, 1);
    repeat (5) step(1, 0, 4'hE, 1);
    step(1, 1, 4'hF, 1);
    step(1, 0, 4'h0, 1);
    step(0, 1, 4'h9, 1);
    hist = '0;
    step(1, 1, 4'h3, 1);
    repeat (5) step(1, 0, 4'h0, 1);
    chk("after_reset", hist, 8'h03);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
